// File: rtl/gpio_ctrl_serial.sv
// Serially configured GPIO pad controller.
// Daisy-chained 8-bit config shift register with a 2-flop pad input sync.
module gpio_ctrl_serial #(
  parameter logic [7:0] CFG_DEFAULT = 8'h0B
) (
  input  logic       serial_clock,
  input  logic       resetn,
  input  logic       serial_data_in,
  input  logic       serial_shift,
  input  logic       serial_load,
  output logic       serial_data_out,
  output logic       cfg_err,
  input  logic       mgmt_gpio_out,
  input  logic       mgmt_gpio_oeb,
  output logic       mgmt_gpio_in,
  input  logic       user_gpio_out,
  input  logic       user_gpio_oeb,
  output logic       user_gpio_in,
  output logic       pad_gpio_out,
  output logic       pad_gpio_outenb,
  output logic       pad_gpio_inenb,
  output logic [2:0] pad_gpio_dm,
  input  logic       pad_gpio_in
);

  logic [7:0] cfg_q, cfg_d;
  logic [7:0] shift_reg_q, shift_reg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       cfg_err_q, cfg_err_d;
  logic       sync1_q, sync2_q;

  logic       mgmt_ena;
  logic       outenb;
  logic       inp_dis;

  assign mgmt_ena = cfg_q[0];
  assign outenb   = cfg_q[1];
  assign inp_dis  = cfg_q[2];

  // Load takes priority over a coincident shift
  always_comb begin
    cfg_d       = cfg_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_err_d   = cfg_err_q;
    if (serial_load) begin
      bit_cnt_d = 4'd0;
      if (bit_cnt_q == 4'd8) begin
        cfg_d = shift_reg_q;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (serial_shift) begin
      shift_reg_d = {shift_reg_q[6:0], serial_data_in};
      if (bit_cnt_q != 4'd8) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      cfg_q       <= CFG_DEFAULT;
      shift_reg_q <= 8'h00;
      bit_cnt_q   <= 4'd0;
      cfg_err_q   <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_err_q   <= cfg_err_d;
      sync1_q     <= pad_gpio_in;
      sync2_q     <= sync1_q;
    end
  end

  assign serial_data_out = shift_reg_q[7];
  assign cfg_err         = cfg_err_q;
  assign mgmt_gpio_in    = sync2_q;
  assign user_gpio_in    = mgmt_ena ? 1'b0 : pad_gpio_in;

  always_comb begin
    if (mgmt_ena) begin
      pad_gpio_out    = mgmt_gpio_out;
      pad_gpio_outenb = outenb | mgmt_gpio_oeb;
    end else begin
      pad_gpio_out    = user_gpio_out;
      pad_gpio_outenb = user_gpio_oeb;
    end
  end

  assign pad_gpio_inenb = inp_dis;
  assign pad_gpio_dm    = cfg_q[5:3];

endmodule

// File: tb/tb_gpio_ctrl_serial.sv
// Directed bench for gpio_ctrl_serial.
// Hand-computed expectations checked with immediate assertions.
module tb_gpio_ctrl_serial;

  logic       serial_clock;
  logic       resetn;
  logic       serial_data_in;
  logic       serial_shift;
  logic       serial_load;
  logic       serial_data_out;
  logic       cfg_err;
  logic       mgmt_gpio_out;
  logic       mgmt_gpio_oeb;
  logic       mgmt_gpio_in;
  logic       user_gpio_out;
  logic       user_gpio_oeb;
  logic       user_gpio_in;
  logic       pad_gpio_out;
  logic       pad_gpio_outenb;
  logic       pad_gpio_inenb;
  logic [2:0] pad_gpio_dm;
  logic       pad_gpio_in;

  int checks = 0;
  int errors = 0;

  gpio_ctrl_serial dut (
    .serial_clock    (serial_clock),
    .resetn          (resetn),
    .serial_data_in  (serial_data_in),
    .serial_shift    (serial_shift),
    .serial_load     (serial_load),
    .serial_data_out (serial_data_out),
    .cfg_err         (cfg_err),
    .mgmt_gpio_out   (mgmt_gpio_out),
    .mgmt_gpio_oeb   (mgmt_gpio_oeb),
    .mgmt_gpio_in    (mgmt_gpio_in),
    .user_gpio_out   (user_gpio_out),
    .user_gpio_oeb   (user_gpio_oeb),
    .user_gpio_in    (user_gpio_in),
    .pad_gpio_out    (pad_gpio_out),
    .pad_gpio_outenb (pad_gpio_outenb),
    .pad_gpio_inenb  (pad_gpio_inenb),
    .pad_gpio_dm     (pad_gpio_dm),
    .pad_gpio_in     (pad_gpio_in)
  );

  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given strobes; returns 1 time unit after it
  task automatic cyc(input logic sh, input logic ld, input logic d);
    serial_shift   = sh;
    serial_load    = ld;
    serial_data_in = d;
    @(posedge serial_clock);
    #1;
    serial_shift = 1'b0;
    serial_load  = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b0, b[i]);
  endtask

  initial begin
    resetn         = 1'b0;
    serial_data_in = 1'b0;
    serial_shift   = 1'b0;
    serial_load    = 1'b0;
    mgmt_gpio_out  = 1'b1;
    mgmt_gpio_oeb  = 1'b0;
    user_gpio_out  = 1'b0;
    user_gpio_oeb  = 1'b1;
    pad_gpio_in    = 1'b0;
    repeat (2) @(posedge serial_clock);
    #1;
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Reset defaults
    chk("rst_dm", 8'(pad_gpio_dm), 8'h1);
    chk("rst_outenb", 8'(pad_gpio_outenb), 8'h1);
    chk("rst_inenb", 8'(pad_gpio_inenb), 8'h0);
    chk("rst_out", 8'(pad_gpio_out), 8'h1);
    chk("rst_err", 8'(cfg_err), 8'h0);
    chk("rst_sdo", 8'(serial_data_out), 8'h0);
    chk("rst_mgmt_in", 8'(mgmt_gpio_in), 8'h0);
    chk("rst_user_in", 8'(user_gpio_in), 8'h0);
    mgmt_gpio_out = 1'b0;
    #1;
    chk("mgmt_out_follow", 8'(pad_gpio_out), 8'h0);

    // Valid load of 8'b00110100
    shift_byte(8'b0011_0100);
    chk("pre_load_dm", 8'(pad_gpio_dm), 8'h1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ld1_dm", 8'(pad_gpio_dm), 8'h6);
    chk("ld1_inenb", 8'(pad_gpio_inenb), 8'h1);
    chk("ld1_outenb", 8'(pad_gpio_outenb), 8'h1);
    chk("ld1_sdo", 8'(serial_data_out), 8'h0);
    chk("ld1_err", 8'(cfg_err), 8'h0);
    chk("ld1_cnt", 8'(dut.bit_cnt_q), 8'h0);
    user_gpio_out = 1'b1;
    user_gpio_oeb = 1'b0;
    #1;
    chk("user_out", 8'(pad_gpio_out), 8'h1);
    chk("user_oeb", 8'(pad_gpio_outenb), 8'h0);

    // Input paths in user mode
    pad_gpio_in = 1'b1;
    #1;
    chk("user_in_now", 8'(user_gpio_in), 8'h1);
    chk("mgmt_in_e0", 8'(mgmt_gpio_in), 8'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mgmt_in_e1", 8'(mgmt_gpio_in), 8'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("mgmt_in_e2", 8'(mgmt_gpio_in), 8'h1);

    // Short load flags an error and leaves cfg alone
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("short_dm", 8'(pad_gpio_dm), 8'h6);
    chk("short_err", 8'(cfg_err), 8'h1);
    chk("short_cnt", 8'(dut.bit_cnt_q), 8'h0);

    // Ten shifts keep the last eight; error stays sticky
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    shift_byte(8'h13);
    chk("sat_cnt", 8'(dut.bit_cnt_q), 8'h8);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ld2_dm", 8'(pad_gpio_dm), 8'h2);
    chk("ld2_inenb", 8'(pad_gpio_inenb), 8'h0);
    chk("ld2_err", 8'(cfg_err), 8'h1);
    chk("ld2_outenb", 8'(pad_gpio_outenb), 8'h1);
    chk("ld2_out", 8'(pad_gpio_out), 8'h0);
    chk("mgmt_user_in0", 8'(user_gpio_in), 8'h0);

    // Seven shifts, then shift+load together
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'(i % 2 == 0));
    chk("seven_sdo", 8'(serial_data_out), 8'h1);
    chk("seven_sr", dut.shift_reg_q, 8'hD5);
    cyc(1'b1, 1'b1, 1'b0);
    chk("coll_dm", 8'(pad_gpio_dm), 8'h2);
    chk("coll_err", 8'(cfg_err), 8'h1);
    chk("coll_cnt", 8'(dut.bit_cnt_q), 8'h0);
    chk("coll_sr", dut.shift_reg_q, 8'hD5);

    // Reset mid-shift
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    resetn = 1'b0;
    #1;
    chk("arst_err", 8'(cfg_err), 8'h0);
    chk("arst_dm", 8'(pad_gpio_dm), 8'h1);
    chk("arst_sdo", 8'(serial_data_out), 8'h0);
    chk("arst_mgmt_in", 8'(mgmt_gpio_in), 8'h0);
    chk("arst_cnt", 8'(dut.bit_cnt_q), 8'h0);
    @(posedge serial_clock);
    #1;
    resetn = 1'b1;
    shift_byte(8'h2A);
    cyc(1'b0, 1'b1, 1'b0);
    chk("ld3_dm", 8'(pad_gpio_dm), 8'h5);
    chk("ld3_err", 8'(cfg_err), 8'h0);
    chk("ld3_out", 8'(pad_gpio_out), 8'h1);
    chk("ld3_outenb", 8'(pad_gpio_outenb), 8'h0);
    chk("ld3_user_in", 8'(user_gpio_in), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
